// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot-time program loader
package loader_pkg;

  localparam int BYTES_PER_WORD = 2;
  localparam int ADDR_W_DEF     = 8;
  localparam int INST_W_DEF     = BYTES_PER_WORD * 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_FINISH,
    S_DONE,
    S_ERROR
  } state_e;

  // States in which the loader consumes a byte from the stream
  function automatic logic accepts_byte(state_e s);
    return (s == S_COUNT) || (s == S_HI) || (s == S_LO) || (s == S_CHK);
  endfunction

  // States from which a start pulse opens a new session
  function automatic logic can_start(state_e s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/loader_csum.sv
// rtl/loader_csum.sv - running XOR accumulator over accepted stream bytes
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (en_i) begin
      sum_d = sum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader feeding instruction RAM
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;

  logic [7:0]        count_q;
  logic [ADDR_W-1:0] idx_q;
  logic [INST_W-1:0] wdata_q;

  logic rx_ready_q, rx_ready_d;
  logic im_we_q, im_we_d;
  logic cpu_reset_q, cpu_reset_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic       xfer;
  logic       last_word;
  logic       csum_ok;
  logic [7:0] count_m1;

  assign xfer      = rx_valid && rx_ready_q;
  // N=0 encodes 256 words, so the last index is N-1 taken mod 256
  assign count_m1  = count_q - 8'd1;
  assign last_word = (idx_q == ADDR_W'(count_m1));

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       error_q, error_d;

  loader_csum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (start && can_start(state_q)),
    .en_i   (xfer),
    .byte_i (rx_data),
    .sum_o  (csum)
  );

  assign csum_ok = (csum == rx_data);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_COUNT;
      S_COUNT:  if (xfer) state_d = S_HI;
      S_HI:     if (xfer) state_d = S_LO;
      S_LO:     if (xfer) state_d = S_WRITE;
      S_WRITE: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_FINISH;
`endif
        end else begin
          state_d = S_HI;
        end
      end
      S_CHK:    if (xfer) state_d = csum_ok ? S_FINISH : S_ERROR;
      S_FINISH: state_d = S_DONE;
      S_DONE:   if (start) state_d = S_COUNT;
      S_ERROR:  if (start) state_d = S_COUNT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up
  // with the state it describes.
  always_comb begin
    rx_ready_d  = accepts_byte(state_d);
    im_we_d     = (state_d == S_WRITE);
    cpu_reset_d = (state_d != S_DONE);
    busy_d      = !can_start(state_d);
    done_d      = (state_d == S_DONE);
`ifdef LOADER_CHECKSUM_EN
    error_d     = (state_d == S_ERROR);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      error_q     <= 1'b0;
`endif
    end else begin
      rx_ready_q  <= rx_ready_d;
      im_we_q     <= im_we_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LOADER_CHECKSUM_EN
      error_q     <= error_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 8'h00;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (start && can_start(state_q)) begin
        idx_q <= '0;
      end
      case (state_q)
        S_COUNT: if (xfer) begin
          count_q <= rx_data;
          idx_q   <= '0;
        end
        S_HI:    if (xfer) wdata_q[INST_W-1 -: 8] <= rx_data;
        S_LO:    if (xfer) wdata_q[7:0] <= rx_data;
        S_WRITE: if (!last_word) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = idx_q;
  assign im_wdata  = wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl[3];

  int         n_chk  = 0;
  int         n_fail = 0;
  int         we_cnt = 0;
  int         we_zero = 0;
  logic [7:0]  last_addr;
  logic [15:0] last_data;
  logic [7:0]  tb_xor;

  always @(negedge clk) begin
    if (im_we) begin
      we_cnt++;
      last_addr = im_addr;
      last_data = im_wdata;
      if (im_addr == 8'd0) we_zero++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      t++;
      if (t > 50) begin
        check("send_byte_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    tb_xor   = tb_xor ^ b;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    tb_xor = 8'h00;
  endtask

  // Entered in WRITE of the last word; ends in DONE.
  task automatic finish_load(input string tag);
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_xor);
`else
    @(posedge clk);
    #1;
`endif
    check({tag, "_finish_done"}, done, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_table(input string tag, input int gap);
    int w0;
    pulse_start();
    check({tag, "_busy_start"}, busy, 1'b1);
    check({tag, "_cpu_reset_start"}, cpu_reset, 1'b1);
    w0 = we_cnt;
    send_byte(8'd3);
    for (int i = 0; i < 3; i++) begin
      send_byte(tbl[i].hi);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check({tag, "_gap_ready"}, rx_ready, 1'b1);
        check({tag, "_gap_we"}, im_we, 1'b0);
        @(posedge clk);
        #1;
      end
      send_byte(tbl[i].lo);
      check({tag, "_we"}, im_we, 1'b1);
      check({tag, "_addr"}, im_addr, tbl[i].exp_addr);
      check({tag, "_data"}, im_wdata, tbl[i].exp_data);
    end
    finish_load(tag);
    check({tag, "_we_count"}, we_cnt - w0, 3);
  endtask

  initial begin
    int w0;
    int z0;
    tbl[0] = '{hi: 8'h12, lo: 8'h34, exp_addr: 8'd0, exp_data: 16'h1234};
    tbl[1] = '{hi: 8'hA0, lo: 8'hFF, exp_addr: 8'd1, exp_data: 16'hA0FF};
    tbl[2] = '{hi: 8'h00, lo: 8'h01, exp_addr: 8'd2, exp_data: 16'h0001};

    reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tb_xor = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_im_we", im_we, 1'b0);
    check("rst_im_addr", im_addr, 8'd0);
    check("rst_im_wdata", im_wdata, 16'd0);

    // Byte offered in IDLE must not be consumed
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("idle_rx_ready", rx_ready, 1'b0);

    run_table("load3", 0);
    run_table("gap", 5);

    // N=0: 256 words from the byte sequence k[7:0]
    pulse_start();
    w0 = we_cnt; z0 = we_zero;
    send_byte(8'd0);
    for (int k = 0; k < 512; k++) send_byte(8'(k));
    check("n0_last_we", im_we, 1'b1);
    check("n0_last_addr_now", im_addr, 8'd255);
    finish_load("n0");
    check("n0_we_count", we_cnt - w0, 256);
    check("n0_last_addr", last_addr, 8'd255);
    check("n0_last_data", last_data, 16'hFEFF);
    check("n0_addr0_writes", we_zero - z0, 1);

    // Reset during the second word of a 4-word load
    pulse_start();
    send_byte(8'd4);
    send_byte(8'hDE); send_byte(8'hAD);
    send_byte(8'hC0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_cpu_reset", cpu_reset, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rx_ready", rx_ready, 1'b0);
    w0 = we_cnt;
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("mid_rst_no_we", we_cnt - w0, 0);
    run_table("after_rst", 0);

    // Restart from DONE with a single word
    pulse_start();
    check("restart_done", done, 1'b0);
    check("restart_cpu_reset", cpu_reset, 1'b1);
    check("restart_addr", im_addr, 8'd0);
    w0 = we_cnt;
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
    check("restart_we", im_we, 1'b1);
    check("restart_wr_addr", im_addr, 8'd0);
    check("restart_wr_data", im_wdata, 16'hBEEF);
    finish_load("restart");
    check("restart_we_count", we_cnt - w0, 1);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h27);
    @(posedge clk);
    #1;
    check("csum_ok_done", done, 1'b1);
    check("csum_ok_error", error, 1'b0);
    pulse_start();
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h00);
    check("csum_bad_error", error, 1'b1);
    check("csum_bad_cpu_reset", cpu_reset, 1'b1);
    check("csum_bad_done", done, 1'b0);
    check("csum_bad_busy", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the instruction memory and program counter.
- Receives a program as a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words into the writable instruction RAM at addresses 0..N-1.
- Holds the processor in reset until loading completes, then releases it so the PC starts fetching at address 0.

Parameters:
- ADDR_W, 8, instruction address width; matches the 8-bit PC.
- INST_W, 16, instruction word width; fixed at 2 bytes per word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle; transfer when rx_valid && rx_ready.
- im_we  output  1  instruction RAM write strobe, one-cycle pulse.
- im_addr  output  ADDR_W  instruction RAM write address.
- im_wdata  output  INST_W  instruction RAM write data.
- cpu_reset  output  1  reset to PC/stack/registers; high while not loaded.
- busy  output  1  load session in progress.
- done  output  1  program loaded and CPU released.
- error  output  1  load aborted (checksum build only; tied 0 otherwise).

Behaviour:
- Reset values:
  - cpu_reset=1, busy=0, done=0, error=0, rx_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - Internal state IDLE; word counter and byte counters cleared.
- All outputs are registered. Reset applied mid-session aborts immediately: no further im_we, cpu_reset=1, RAM contents left as is.
- Stream format: COUNT byte N, then N words, each sent high byte first, then low byte. N=0 encodes 256 words.
- States and transitions:
  - IDLE: rx_ready=0. On start go to COUNT, busy=1, cpu_reset=1.
  - COUNT: rx_ready=1. On transfer, latch N and set word index=0; go to HI.
  - HI: rx_ready=1. On transfer, latch rx_data into im_wdata[15:8]; go to LO.
  - LO: rx_ready=1. On transfer, latch rx_data into im_wdata[7:0]; go to WRITE.
  - WRITE: rx_ready=0; im_we=1 for exactly this cycle, with im_addr=word index.
    - If word index==N-1 (mod 256), go to FINISH (or CHK when the macro is defined).
    - Otherwise increment the word index and go to HI.
  - FINISH: go to DONE next cycle.
  - DONE: done=1, busy=0, cpu_reset=0; stays until start or reset.
  - ERROR: error=1, busy=0, cpu_reset=1; stays until start or reset.
- Latency:
  - im_we asserts in the cycle after the low byte transfer.
  - Minimum 3 cycles per word; rx_valid gaps stall without limit.
- rx_ready is low in IDLE, WRITE, FINISH, DONE and ERROR. Bytes offered in those states are not consumed.
- start in DONE or ERROR begins a new session:
  - done and error clear the next cycle; cpu_reset re-asserts.
  - The word index restarts at 0.
- start while busy=1 is ignored.
- Address wrap: im_addr is ADDR_W bits. N=0 writes addresses 0..255 and finishes at 255; no overflow write.
- Byte transfer and start in the same cycle while busy: the transfer is taken, start is ignored.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all bytes (COUNT plus data) is kept.
  - After the last WRITE, state CHK (rx_ready=1) accepts one checksum byte.
  - If the running XOR equals the checksum byte, go to FINISH/DONE.
  - Otherwise go to ERROR: error=1, cpu_reset stays 1.
- Not defined: no CHK state, no checksum byte, error tied 0.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, COUNT, HI, LO, WRITE, CHK, FINISH, DONE, ERROR);
  - ADDR_W/INST_W defaults;
  - constant BYTES_PER_WORD=2.
- One sub-module, loader_csum: XOR accumulator with clear, enable and byte inputs. It is instantiated only under LOADER_CHECKSUM_EN.

Test Plan:
- Reset, then start; send N=3, words 16'h1234, 16'hA0FF, 16'h0001 with rx_valid held high -> im_we pulses with (addr 0, 1234), (1, A0FF), (2, 0001); done=1 and cpu_reset=0 two cycles after the last im_we.
- Same load with rx_valid dropped for 5 cycles between the high and low byte -> identical writes; no im_we during the gap; rx_ready stays 1.
- N=0 with 512 bytes of value k[7:0] -> 256 writes, last at im_addr=255; no write to address 0 after the first.
- Assert reset during word 2 of a 4-word load -> next cycle cpu_reset=1, busy=0, no further im_we; a fresh start and load completes normally.
- After DONE, pulse start and load N=1 word 16'hBEEF -> done drops and cpu_reset rises the cycle after start; single write (0, BEEF); then DONE again.
- LOADER_CHECKSUM_EN: N=1, bytes 01 12 34 + checksum 27 -> DONE. Same stream with checksum 00 -> error=1, cpu_reset=1, done=0.
